// File: rtl/key_debounce_onehot.sv
// key_debounce_onehot
//   Four raw push-buttons are synchronised and debounced independently, then
//   arbitrated into a registered one-hot key vector with a one-cycle press strobe.
//   keys is always one-hot or all-zero.
//   Optional feature macro: KEY_REPEAT_EN (auto-repeat key_pulse while a key is held).
//
//   Selection FSM states:
//   state | meaning
//   IDLE  | no key selected, keys = 0; waits for any debounced press
//   HELD  | one key selected and driven on keys; others ignored until it releases
module key_debounce_onehot #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned CNT_W           = 20,
   parameter int unsigned REPEAT_DELAY    = 50000000,
   parameter int unsigned REPEAT_PERIOD   = 10000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] btn_raw,
   output logic [3:0] keys,
   output logic       key_pulse
);

   // Terminal count for the per-key stability counters.
   localparam logic [CNT_W-1:0] DEB_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {
      IDLE = 1'b0,
      HELD = 1'b1
   } state_t;

   logic [3:0]       s1;
   logic [3:0]       s2;
   logic [3:0]       db;
   logic [CNT_W-1:0] cnt [4];

   state_t           state_q;
   state_t           state_d;
   logic [1:0]       sel_q;
   logic [1:0]       sel_d;
   logic [1:0]       low_idx;
   logic [3:0]       keys_d;
   logic             pulse_d;

`ifdef KEY_REPEAT_EN
   logic [31:0]      rpt_q;
   logic [31:0]      rpt_d;
`endif

   // Two-flop synchroniser per button.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= btn_raw;
         s2 <= s1;
      end
   end

   // Per-key debounce: accept a new level only after it has been stable for the full count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db <= '0;
         for (int i = 0; i < 4; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (s2[i] == db[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == DEB_TC) begin
               db[i]  <= s2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Lowest-index debounced key wins arbitration.
   always_comb begin
      low_idx = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (db[i]) begin
            low_idx = 2'(i);
         end
      end
   end

   // FSM state, selection and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         sel_q     <= '0;
         keys      <= '0;
         key_pulse <= 1'b0;
`ifdef KEY_REPEAT_EN
         rpt_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         keys      <= keys_d;
         key_pulse <= pulse_d;
`ifdef KEY_REPEAT_EN
         rpt_q     <= rpt_d;
`endif
      end
   end

   // Next-state and output decode; the pulse is only ever raised for one cycle.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      keys_d  = keys;
      pulse_d = 1'b0;
`ifdef KEY_REPEAT_EN
      rpt_d   = '0;
`endif
      case (state_q)
         IDLE: begin
            keys_d = '0;
            if (db != 4'b0000) begin
               sel_d   = low_idx;
               keys_d  = 4'b0001 << low_idx;
               pulse_d = 1'b1;
               state_d = HELD;
`ifdef KEY_REPEAT_EN
               rpt_d   = 32'(REPEAT_DELAY - 1);
`endif
            end
         end
         HELD: begin
            if (!db[sel_q]) begin
               keys_d  = '0;
               state_d = IDLE;
            end else begin
`ifdef KEY_REPEAT_EN
               // Down-counter reloads with the period after each repeat pulse.
               if (rpt_q == 32'd0) begin
                  pulse_d = 1'b1;
                  rpt_d   = 32'(REPEAT_PERIOD - 1);
               end else begin
                  rpt_d   = rpt_q - 32'd1;
               end
`endif
            end
         end
         default: begin
            state_d = IDLE;
            keys_d  = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_key_debounce_onehot.sv
// Scoreboard bench for key_debounce_onehot (DEBOUNCE_CYCLES=4, repeat 10/5).
// A stimulus process drives btn_raw/rst_n on the falling edge, advances a
// behavioural model and queues the expected outputs for the next rising edge;
// a monitor process pops and compares after every rising edge.
module tb_key_debounce_onehot;

   localparam int D  = 4;
   localparam int RD = 10;
   localparam int RP = 5;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] btn_raw;
   logic [3:0] keys;
   logic       key_pulse;

   always #5 clk = ~clk;

   key_debounce_onehot #(
      .DEBOUNCE_CYCLES(D),
      .CNT_W(20),
      .REPEAT_DELAY(RD),
      .REPEAT_PERIOD(RP)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .btn_raw(btn_raw),
      .keys(keys),
      .key_pulse(key_pulse)
   );

   typedef struct {
      logic [3:0] keys;
      logic       pulse;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   cyc         = 0;

   // behavioural model state
   logic [3:0] rq[$];    // raw samples taken since reset (last two kept)
   logic [3:0] s2q[$];   // synchronised level seen by the debouncer, last D edges
   logic [3:0] m_db;
   int         m_sel;    // -1 = nothing selected
   int         m_age;    // edges since the current key was accepted
   logic [3:0] m_keys;
   logic       m_pulse;

   task automatic model_reset();
      rq.delete();
      s2q.delete();
      m_db    = 4'b0000;
      m_sel   = -1;
      m_age   = 0;
      m_keys  = 4'b0000;
      m_pulse = 1'b0;
   endtask

   // One rising edge with reset released and raw level 'raw' sampled.
   task automatic model_edge(input logic [3:0] raw);
      logic [3:0] s2old;
      logic [3:0] db_old;
      bit         all_diff;
      s2old = (rq.size() >= 2) ? rq[rq.size()-2] : 4'b0000;
      rq.push_back(raw);
      if (rq.size() > 2) void'(rq.pop_front());
      s2q.push_back(s2old);
      if (s2q.size() > D) void'(s2q.pop_front());
      db_old = m_db;

      if (m_sel < 0) begin
         m_pulse = 1'b0;
         m_keys  = 4'b0000;
         if (db_old != 4'b0000) begin
            for (int i = 3; i >= 0; i--) if (db_old[i]) m_sel = i;
            m_keys  = 4'b0001 << m_sel;
            m_pulse = 1'b1;
            m_age   = 0;
         end
      end else begin
         m_pulse = 1'b0;
         if (!db_old[m_sel]) begin
            m_sel  = -1;
            m_keys = 4'b0000;
         end else begin
            m_age++;
`ifdef KEY_REPEAT_EN
            if (m_age == RD || (m_age > RD && (m_age - RD) % RP == 0)) m_pulse = 1'b1;
`endif
         end
      end

      // a level is accepted once the last D synchronised samples all disagree with it
      if (s2q.size() == D) begin
         for (int i = 0; i < 4; i++) begin
            all_diff = 1'b1;
            foreach (s2q[k]) if (s2q[k][i] == m_db[i]) all_diff = 1'b0;
            if (all_diff) m_db[i] = ~m_db[i];
         end
      end
   endtask

   task automatic step(input logic [3:0] raw, input logic rn);
      exp_t e;
      @(negedge clk);
      btn_raw = raw;
      if (!rn && rst_n) begin
         rst_n = 1'b0;
         #1;
         vectors++;
         if (keys !== 4'b0000 || key_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset t=%0t keys=%b pulse=%b required keys=0000 pulse=0",
                     $time, keys, key_pulse);
         end
      end
      rst_n = rn;
      if (!rn) model_reset();
      else     model_edge(raw);
      cyc++;
      e.keys  = m_keys;
      e.pulse = m_pulse;
      e.cyc   = cyc;
      exp_q.push_back(e);
   endtask

   task automatic hold(input logic [3:0] raw, input int n);
      for (int i = 0; i < n; i++) step(raw, 1'b1);
   endtask

   // monitor: compare DUT against queued expectations plus output invariants
   initial begin : monitor
      exp_t e;
      logic prev_pulse;
      prev_pulse = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            vectors++;
            if (keys !== e.keys || key_pulse !== e.pulse) begin
               miscompares++;
               $display("FAIL outputs cyc=%0d keys=%b pulse=%b required keys=%b pulse=%b",
                        e.cyc, keys, key_pulse, e.keys, e.pulse);
            end
            if (key_pulse === 1'b1 && (keys === 4'b0000 || prev_pulse === 1'b1)) begin
               miscompares++;
               $display("FAIL pulse_rule cyc=%0d keys=%b pulse=%b prev_pulse=%b",
                        e.cyc, keys, key_pulse, prev_pulse);
            end
            if ($countones(keys) > 1) begin
               miscompares++;
               $display("FAIL onehot cyc=%0d keys=%b required one-hot or zero", e.cyc, keys);
            end
            prev_pulse = key_pulse;
         end
      end
   end

   initial begin : stimulus
      logic [3:0] base;
      logic [3:0] r;
      rst_n   = 1'b0;
      btn_raw = 4'b1111;
      model_reset();
      #1;
      vectors++;
      if (keys !== 4'b0000 || key_pulse !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_start keys=%b pulse=%b required keys=0000 pulse=0", keys, key_pulse);
      end

      // reset held with all buttons pressed
      for (int i = 0; i < 6; i++) step(4'b1111, 1'b0);
      hold(4'b0000, 6);

      // clean press and release
      hold(4'b0001, 20);
      hold(4'b0000, 12);

      // bounce on bit 1, then steady press
      for (int k = 0; k < 5; k++) begin
         hold(4'b0010, 3);
         hold(4'b0000, 1);
      end
      hold(4'b0010, 15);
      hold(4'b0000, 12);

      // arbitration, hand-over, and ignored extra press while held
      hold(4'b0110, 15);
      hold(4'b0100, 15);
      hold(4'b1100, 15);
      hold(4'b0000, 12);

      // reset mid-hold with the button still pressed
      hold(4'b0001, 15);
      step(4'b0001, 1'b0);
      step(4'b0001, 1'b0);
      hold(4'b0001, 15);
      hold(4'b0000, 12);

      // long hold (auto-repeat when enabled)
      hold(4'b1000, 40);
      hold(4'b0000, 12);

      // simultaneous presses: lowest index wins
      hold(4'b1111, 15);
      hold(4'b0000, 12);

      // randomized levels with per-bit bounce and occasional reset
      base = 4'b0000;
      for (int seg = 0; seg < 400; seg++) begin
         if ($urandom_range(0, 3) == 0) base = 4'($urandom_range(0, 15));
         r = base;
         if ($urandom_range(0, 2) == 0) r = base ^ 4'($urandom_range(0, 15));
         if ($urandom_range(0, 60) == 0) begin
            step(r, 1'b0);
            step(r, 1'b0);
         end else begin
            hold(r, $urandom_range(1, 9));
         end
      end
      hold(4'b0000, 12);

      @(negedge clk);
      @(negedge clk);
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL queue_drain left=%0d required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
